// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one request, waits
// WAIT_CYCLES busy cycles, then returns a single response beat.
// Optional feature macro: DMEM_RANGE_CHECK_EN (adds resp_err and rejects
// requests whose upper address bits [15:ADDR_W] are nonzero).
module data_mem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
`ifdef DMEM_RANGE_CHECK_EN
    output logic        resp_err,
`endif
    output logic        stall
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [7:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_cnt;
    logic [7:0]          w_cnt_nxt;
    logic                r_op_rd;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_idx;
    logic [15:0]         r_wdata;
    logic                r_resp_valid;
    logic [15:0]         r_resp_rdata;

    // Storage survives reset; it starts out all zero.
    logic [15:0]         r_mem [DEPTH] = '{default: 16'h0000};

    logic                w_req;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_rd_op;
    logic                w_wr_op;
    logic [ADDR_W-1:0]   w_idx_op;
    logic [15:0]         w_wdata_op;
    logic                w_oor_req;
    logic                w_oor_op;
    logic [15:0]         w_rdata_nxt;
    logic                w_commit;

    assign w_req    = req_read | req_write;
    assign w_accept = (r_state == S_IDLE) & w_req;

`ifdef DMEM_RANGE_CHECK_EN
    logic r_oor;
    logic r_resp_err;
    assign w_oor_req = |req_addr[15:ADDR_W];
    assign w_oor_op  = (r_state == S_IDLE) ? w_oor_req : r_oor;
    assign resp_err  = r_resp_err;
`else
    logic w_unused_upper;
    assign w_unused_upper = ^req_addr[15:ADDR_W];
    assign w_oor_req      = 1'b0;
    assign w_oor_op       = 1'b0;
`endif

    // Next-state, counter and response-data selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_BUSY;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // With zero wait states the response edge is the accept edge, so
        // operands come straight from the request rather than the latches.
        w_rd_op    = (r_state == S_IDLE) ? req_read                : r_op_rd;
        w_wr_op    = (r_state == S_IDLE) ? req_write               : r_op_wr;
        w_idx_op   = (r_state == S_IDLE) ? req_addr[ADDR_W-1:0]    : r_idx;
        w_wdata_op = (r_state == S_IDLE) ? req_wdata               : r_wdata;

        w_rdata_nxt = (w_rd_op & ~w_oor_op) ? r_mem[w_idx_op] : 16'h0000;
        w_commit    = w_enter_resp & w_wr_op & ~w_oor_op & ~reset;
    end

    // State, counter, operand latches and response registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_op_rd      <= 1'b0;
            r_op_wr      <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= 16'h0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 16'h0000;
`ifdef DMEM_RANGE_CHECK_EN
            r_oor        <= 1'b0;
            r_resp_err   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_resp_valid <= w_enter_resp;
            if (w_accept) begin
                r_op_rd <= req_read;
                r_op_wr <= req_write;
                r_idx   <= req_addr[ADDR_W-1:0];
                r_wdata <= req_wdata;
`ifdef DMEM_RANGE_CHECK_EN
                r_oor   <= w_oor_req;
`endif
            end
            if (w_enter_resp) begin
                r_resp_rdata <= w_rdata_nxt;
            end
`ifdef DMEM_RANGE_CHECK_EN
            r_resp_err <= w_enter_resp & w_oor_op;
`endif
        end
    end

    // Write commit on the edge entering RESP (read-before-write by NBA order).
    always_ff @(posedge clock) begin
        if (w_commit) begin
            r_mem[w_idx_op] <= w_wdata_op;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign stall      = ((r_state == S_IDLE) & w_req) | (r_state == S_BUSY);

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: instance a uses WAIT_CYCLES=2,
// instance b uses WAIT_CYCLES=0. Honours DMEM_RANGE_CHECK_EN.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        a_rd = 1'b0, a_wr = 1'b0;
    logic [15:0] a_addr = 16'h0, a_wdata = 16'h0;
    logic        a_ready, a_valid, a_stall;
    logic [15:0] a_rdata;

    logic        b_rd = 1'b0, b_wr = 1'b0;
    logic [15:0] b_addr = 16'h0, b_wdata = 16'h0;
    logic        b_ready, b_valid, b_stall;
    logic [15:0] b_rdata;

`ifdef DMEM_RANGE_CHECK_EN
    logic        a_err, b_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) u_a (
        .clock(clock), .reset(reset),
        .req_read(a_rd), .req_write(a_wr), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ready(a_ready), .resp_valid(a_valid), .resp_rdata(a_rdata),
`ifdef DMEM_RANGE_CHECK_EN
        .resp_err(a_err),
`endif
        .stall(a_stall)
    );

    data_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) u_b (
        .clock(clock), .reset(reset),
        .req_read(b_rd), .req_write(b_wr), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .resp_valid(b_valid), .resp_rdata(b_rdata),
`ifdef DMEM_RANGE_CHECK_EN
        .resp_err(b_err),
`endif
        .stall(b_stall)
    );

    // Issue one request on instance a and wait (bounded) for its response.
    // lat counts falling edges after the accept edge until resp_valid is seen.
    task automatic acc_a(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] wdata, output logic [15:0] rdata,
                         output int lat, output logic err);
        @(negedge clock);
        a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
        @(negedge clock);
        a_rd = 1'b0; a_wr = 1'b0;
        lat = 1;
        while (!a_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        rdata = a_rdata;
`ifdef DMEM_RANGE_CHECK_EN
        err = a_err;
`else
        err = 1'b0;
`endif
    endtask

    task automatic test_reset();
        n_checks++;
        if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_rdata !== 16'h0 || a_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_a: ready=%b valid=%b rdata=%h stall=%b, want 1 0 0000 0",
                     a_ready, a_valid, a_rdata, a_stall);
        end
        n_checks++;
        if (b_ready !== 1'b1 || b_valid !== 1'b0 || b_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_b: ready=%b valid=%b rdata=%h, want 1 0 0000",
                     b_ready, b_valid, b_rdata);
        end
    endtask

    task automatic test_write_timing();
        @(negedge clock);
        a_wr = 1'b1; a_addr = 16'h0005; a_wdata = 16'h1234;
        #1;
        n_checks++;
        if (a_stall !== 1'b1 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_idle_stall: stall=%b ready=%b, want 1 1", a_stall, a_ready);
        end
        @(negedge clock);
        a_wr = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (a_ready !== 1'b0 || a_stall !== 1'b1 || a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_busy%0d: ready=%b stall=%b valid=%b, want 0 1 0",
                         i, a_ready, a_stall, a_valid);
            end
            @(negedge clock);
        end
        n_checks++;
        if (a_valid !== 1'b1 || a_rdata !== 16'h0000 || a_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_resp: valid=%b rdata=%h stall=%b, want 1 0000 0",
                     a_valid, a_rdata, a_stall);
        end
        @(negedge clock);
        n_checks++;
        if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_back_idle: valid=%b ready=%b, want 0 1", a_valid, a_ready);
        end
    endtask

    task automatic test_read();
        logic [15:0] d; int lat; logic e;
        acc_a(1'b1, 1'b0, 16'h0005, 16'h0, d, lat, e);
        n_checks++;
        if (d !== 16'h1234 || lat !== 3) begin
            n_fail++;
            $display("FAIL read5: rdata=%h lat=%0d, want 1234 3", d, lat);
        end
        @(negedge clock);
        n_checks++;
        if (a_stall !== 1'b0 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL read_idle: stall=%b ready=%b, want 0 1", a_stall, a_ready);
        end
    endtask

    task automatic test_rmw();
        logic [15:0] d; int lat; logic e;
        acc_a(1'b1, 1'b1, 16'h0005, 16'hBEEF, d, lat, e);
        n_checks++;
        if (d !== 16'h1234 || lat !== 3) begin
            n_fail++;
            $display("FAIL rmw_old: rdata=%h lat=%0d, want 1234 3", d, lat);
        end
        acc_a(1'b1, 1'b0, 16'h0005, 16'h0, d, lat, e);
        n_checks++;
        if (d !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rmw_new: rdata=%h, want beef", d);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] d; int lat; logic e;
        @(negedge clock);
        a_wr = 1'b1; a_addr = 16'h0007; a_wdata = 16'h5555;
        @(negedge clock);
        a_wr = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (a_valid !== 1'b0 || a_rdata !== 16'h0000 || a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reset: valid=%b rdata=%h ready=%b, want 0 0000 1",
                     a_valid, a_rdata, a_ready);
        end
        #2;
        reset = 1'b0;
        acc_a(1'b1, 1'b0, 16'h0007, 16'h0, d, lat, e);
        n_checks++;
        if (d !== 16'h0000 || lat !== 3) begin
            n_fail++;
            $display("FAIL abort_read7: rdata=%h lat=%0d, want 0000 3", d, lat);
        end
    endtask

    task automatic test_zero_wait();
        @(negedge clock);
        b_wr = 1'b1; b_addr = 16'h0003; b_wdata = 16'h4321;
        @(negedge clock);
        b_wr = 1'b0;
        n_checks++;
        if (b_valid !== 1'b1 || b_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL zw_write: valid=%b rdata=%h, want 1 0000", b_valid, b_rdata);
        end
        @(negedge clock);
        b_rd = 1'b1; b_addr = 16'h0003;
        #1;
        n_checks++;
        if (b_stall !== 1'b1 || b_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL zw_stall: stall=%b ready=%b, want 1 1", b_stall, b_ready);
        end
        @(negedge clock);
        n_checks++;
        if (b_valid !== 1'b1 || b_rdata !== 16'h4321 || b_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_read: valid=%b rdata=%h ready=%b, want 1 4321 0",
                     b_valid, b_rdata, b_ready);
        end
        b_addr = 16'h0009;
        @(negedge clock);
        n_checks++;
        if (b_valid !== 1'b0 || b_rdata !== 16'h4321 || b_ready !== 1'b1 || b_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL zw_hold: valid=%b rdata=%h ready=%b stall=%b, want 0 4321 1 1",
                     b_valid, b_rdata, b_ready, b_stall);
        end
        @(negedge clock);
        b_rd = 1'b0;
        n_checks++;
        if (b_valid !== 1'b1 || b_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL zw_next: valid=%b rdata=%h, want 1 0000", b_valid, b_rdata);
        end
    endtask

    task automatic test_range();
        logic [15:0] d; int lat; logic e;
        acc_a(1'b0, 1'b1, 16'h8005, 16'hAAAA, d, lat, e);
`ifdef DMEM_RANGE_CHECK_EN
        n_checks++;
        if (e !== 1'b1 || d !== 16'h0000 || lat !== 3) begin
            n_fail++;
            $display("FAIL range_err: err=%b rdata=%h lat=%0d, want 1 0000 3", e, d, lat);
        end
        @(negedge clock);
        n_checks++;
        if (a_err !== 1'b0) begin
            n_fail++;
            $display("FAIL range_err_clr: err=%b, want 0", a_err);
        end
        acc_a(1'b1, 1'b0, 16'h0005, 16'h0, d, lat, e);
        n_checks++;
        if (d !== 16'hBEEF || e !== 1'b0) begin
            n_fail++;
            $display("FAIL range_read5: rdata=%h err=%b, want beef 0", d, e);
        end
`else
        n_checks++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL alias_write: lat=%0d, want 3", lat);
        end
        acc_a(1'b1, 1'b0, 16'h0005, 16'h0, d, lat, e);
        n_checks++;
        if (d !== 16'hAAAA) begin
            n_fail++;
            $display("FAIL alias_read5: rdata=%h, want aaaa", d);
        end
`endif
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b0;
        test_write_timing();
        test_read();
        test_rmw();
        test_reset_abort();
        test_zero_wait();
        test_range();
        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
